// File: rtl/seg7_scan_ctrl_if.sv
// Bundle of control inputs and display outputs for seg7_scan_ctrl.
// The driver (master) supplies value/load/enable and observes the display lines.
interface seg7_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  modport master (
    output en, load, value_in, dp_in,
    input  seg, dp, an, pending, frame_tick
  );

  modport slave (
    input  en, load, value_in, dp_in,
    output seg, dp, an, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with blanking guard and frame-aligned updates.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits 3..1.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {StBlank, StDrive} slot_e;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [15:0]     active_q, shadow_q;
  logic [3:0]      active_dp_q, shadow_dp_q;
  logic            pending_q;
  logic            frame_tick_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  logic            term;
  logic            wrap;
  slot_e           slot_st;
  logic [3:0]      nib;
  logic            suppress;
  logic [6:0]      seg_dec;

  assign term    = (32'(cnt_q) == REFRESH_DIV - 1);
  assign wrap    = term && (idx_q == 2'd3);
  assign slot_st = (32'(cnt_q) >= BLANK_CYCLES) ? StDrive : StBlank;

  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      2'd0: nib = active_q[3:0];
      2'd1: nib = active_q[7:4];
      2'd2: nib = active_q[11:8];
      2'd3: nib = active_q[15:12];
      default: nib = 4'h0;
    endcase
  end

  always_comb begin
    suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (idx_q)
      2'd3: suppress = (active_q[15:12] == 4'h0);
      2'd2: suppress = (active_q[15:8] == 8'h00);
      2'd1: suppress = (active_q[15:4] == 12'h000);
      default: suppress = 1'b0;
    endcase
`endif
  end

  // abcdefg order, 0 = lit
  always_comb begin
    seg_dec = 7'b1111111;
    unique case (nib)
      4'h0: seg_dec = 7'b0000001;
      4'h1: seg_dec = 7'b1001111;
      4'h2: seg_dec = 7'b0010010;
      4'h3: seg_dec = 7'b0000110;
      4'h4: seg_dec = 7'b1001100;
      4'h5: seg_dec = 7'b0100100;
      4'h6: seg_dec = 7'b0100000;
      4'h7: seg_dec = 7'b0001111;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0000100;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b1100000;
      4'hC: seg_dec = 7'b0110001;
      4'hD: seg_dec = 7'b1000010;
      4'hE: seg_dec = 7'b0110000;
      4'hF: seg_dec = 7'b0111000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      active_q     <= 16'h0000;
      shadow_q     <= 16'h0000;
      active_dp_q  <= 4'h0;
      shadow_dp_q  <= 4'h0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else if (!bus.en) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      // Nothing is scanning, so a load can take effect at once.
      if (bus.load) begin
        active_q    <= bus.value_in;
        active_dp_q <= bus.dp_in;
        pending_q   <= 1'b0;
      end
    end else begin
      cnt_q        <= term ? '0 : cnt_q + 1'b1;
      idx_q        <= term ? idx_q + 2'd1 : idx_q;
      frame_tick_q <= wrap;
      if (wrap) begin
        pending_q <= 1'b0;
        if (bus.load) begin
          active_q    <= bus.value_in;
          active_dp_q <= bus.dp_in;
        end else if (pending_q) begin
          active_q    <= shadow_q;
          active_dp_q <= shadow_dp_q;
        end
      end else if (bus.load) begin
        shadow_q    <= bus.value_in;
        shadow_dp_q <= bus.dp_in;
        pending_q   <= 1'b1;
      end
      unique case (slot_st)
        StBlank: begin
          an_q  <= 4'b1111;
          seg_q <= 7'b1111111;
          dp_q  <= 1'b1;
        end
        StDrive: begin
          an_q  <= ~(4'b0001 << idx_q);
          seg_q <= suppress ? 7'b1111111 : seg_dec;
          dp_q  <= ~active_dp_q[idx_q];
        end
        default: begin
          an_q  <= 4'b1111;
          seg_q <= 7'b1111111;
          dp_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.
- Takes a 16-bit hex value (4 nibbles) plus per-digit decimal points and rotates the active anode across AN0..AN3.
- Decodes each nibble to active-low segments and inserts a blanking guard at every digit switch to prevent ghosting.
- Double-buffers the displayed value so updates take effect only on frame boundaries, so no torn frames.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (>= 4)
BLANK_CYCLES, 16, guard cycles at start of each slot with all anodes off (1 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark
load  in  1  single-cycle strobe: capture value_in/dp_in
value_in  in  16  digit3=[15:12] .. digit0=[3:0]
dp_in  in  4  decimal point per digit, 1 = lit
seg  out  7  active-low segments, seg[6]=a .. seg[0]=g
dp  out  1  active-low decimal point
an  out  4  active-low anodes, an[i] drives digit i
pending  out  1  loaded value waiting for frame boundary
frame_tick  out  1  one-cycle pulse when the digit3->digit0 wrap occurs

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. On reset: an=4'b1111, seg=7'b1111111, dp=1, pending=0, frame_tick=0.
- Also on reset: slot counter=0, digit index=0, active and shadow value/dp registers = 0.
- Slot counter counts 0..REFRESH_DIV-1. At the terminal count it returns to 0 and the digit index advances 0->1->2->3->0.
- The 3->0 advance is the frame wrap. frame_tick is high for the single cycle after the wrap edge.
- Per-slot state machine, two states:
  - BLANK: counter < BLANK_CYCLES; an=1111, seg=1111111, dp=1.
  - DRIVE: counter >= BLANK_CYCLES; an[idx]=0 with the other anodes 1, seg=decode(active nibble idx), dp=~active_dp[idx].
- All outputs are registered, with 1-cycle latency from counter/index state.
- Decode table, abcdefg order, 0 = segment lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Load handshake (en=1):
  - load writes value_in/dp_in into the shadow registers and sets pending.
  - At the wrap edge, shadow is copied to active and pending clears.
  - A load while pending=1 overwrites the shadow; last load wins.
  - A load in the same cycle as the wrap bypasses: value_in goes straight to active and pending stays 0.
- en=0:
  - Counter and index are held at 0; outputs are forced to the reset (dark) values.
  - load writes active directly and pending stays 0.
  - frame_tick stays 0.
- en rising: scanning starts with a BLANK slot for digit 0.
- Reset mid-frame: immediate dark outputs; pending shadow is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit i (i=3..1) is suppressed when its active nibble and all higher nibbles are 0. A suppressed digit has seg=1111111 during DRIVE, while its anode still follows the normal scan. dp is unaffected. Digit 0 is never suppressed.
- Undefined: every digit is decoded normally, including leading zeros.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset held low, then released with en=1, no load -> outputs dark for 2 cycles after reset release; then an=1110 and seg=0000001 for 6 cycles; then BLANK again, then an=1101; first frame_tick occurs 32 cycles after scan start.
2. en=1, load value_in=16'h1234, dp_in=4'b0100 mid-frame -> pending=1 until wrap. After wrap: digit0 seg=1001100 (4), digit1 0000110 (3), digit2 0010010 (2) with dp=0, digit3 1001111 (1); pending=0.
3. Two loads (16'hAAAA, then 16'hBEEF) within one frame -> next frame shows F,E,E,b on digits 0..3; AAAA is never displayed.
4. load 16'h00C0 coincident with the wrap cycle -> pending never asserts; the frame just starting shows 0,C,0,0.
5. en=0 for 20 cycles mid-slot, then en=1 -> an=1111 throughout en=0 with no frame_tick; restart shows 2 blank cycles, then digit 0.
6. With LEADING_ZERO_BLANK_EN defined, active=16'h0050 -> digits 3 and 2 DRIVE with seg=1111111; digit1 shows 5 (0100100); digit0 shows 0 (0000001).
